// File: rtl/pattern_pwm_gen.sv
// ---------------------------------------------------------------------------
// pattern_pwm_gen
//   Pattern-based PWM burst generator for the DDS sample path. A rising edge
//   of pwm_en starts a burst. Each pulse sends the latched PAT bits LSB first,
//   with every bit held for duty_num clocks. A low gap of pulse_dessert clocks
//   follows each pulse. The pulse repeats pulse_num times, or repeats until
//   pwm_en falls when pulse_num is 0. busy is high while a burst runs, and
//   valid pulses for one clock when the burst completes.
//
// Parameters
//   _PAT_WIDTH     width of the PAT pattern (>= 1)
//
// Ports
//   clk            system clock; all logic uses the rising edge
//   rst            synchronous, active-high reset
//   pwm_en         run request; rising edge starts, falling edge stops
//   duty_num       clocks per pattern bit (0 is treated as 1)
//   pulse_dessert  low-gap clocks after each pattern (0 = no gap)
//   pulse_num      pattern repetitions (0 = repeat until pwm_en falls)
//   PAT            pattern, sent LSB first; length ends at the highest set bit
//   pwm_out        registered PWM output
//   busy           high while a burst is in progress
//   valid          one-clock completion strobe
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for a rising edge of pwm_en; clears any stop request
// S_PAT  | serialising pattern bits, each held for the latched duty count
// S_GAP  | pwm_out held low for the latched gap count
// S_DONE | single clock with valid=1, then back to S_IDLE
//
module pattern_pwm_gen #(
    parameter int _PAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_en,
    input  logic [7:0]            duty_num,
    input  logic [15:0]           pulse_dessert,
    input  logic [7:0]            pulse_num,
    input  logic [_PAT_WIDTH-1:0] PAT,
    output logic                  pwm_out,
    output logic                  busy,
    output logic                  valid
);

    localparam int IDX_W = $clog2(_PAT_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    pwm_en_dly_q;
    logic                    stop_req_q;
    logic [7:0]              duty_rld_q;
    logic [7:0]              duty_cnt_q;
    logic [15:0]             gap_q;
    logic [15:0]             gap_cnt_q;
    logic [7:0]              pulse_num_q;
    logic [7:0]              pulse_cnt_q;
    logic [_PAT_WIDTH-1:0]   pat_q;
    logic [_PAT_WIDTH-1:0]   sr_q;
    logic [IDX_W-1:0]        last_idx_q;
    logic [IDX_W-1:0]        bit_idx_q;
    logic                    pwm_out_q;
    logic                    busy_q;
    logic                    valid_q;

    logic                    rise;
    logic                    fall;
    logic [IDX_W-1:0]        pat_last_idx;
    logic [7:0]              duty_rld_in;
    logic [_PAT_WIDTH-1:0]   sr_shift;
    logic [7:0]              pulse_cnt_d;
    logic                    pulse_end;
    logic                    stop_now;
    logic                    last_pulse;

    assign rise = pwm_en & ~pwm_en_dly_q;
    assign fall = ~pwm_en & pwm_en_dly_q;

    // Index of the highest set PAT bit. An all-zero pattern yields index 0,
    // giving a one-bit pattern whose value is 0.
    always_comb begin
        pat_last_idx = '0;
        for (int i = 0; i < _PAT_WIDTH; i++) begin
            if (PAT[i]) begin
                pat_last_idx = IDX_W'(i);
            end
        end
    end

    // The duty counter counts down to 0, so it is reloaded with duty-1.
    // A duty of 0 behaves like a duty of 1.
    assign duty_rld_in = (duty_num == 8'd0) ? 8'd0 : (duty_num - 8'd1);

    // The pattern is walked by shifting right. Bit 0 of the shifted value is
    // the next bit to present, so this also works for a one-bit pattern.
    assign sr_shift    = sr_q >> 1;
    assign pulse_cnt_d = pulse_cnt_q + 8'd1;

    // A pulse ends on the last clock of its gap, or on the last clock of the
    // last pattern bit when there is no gap.
    assign pulse_end = ((state_q == S_PAT) && (duty_cnt_q == 8'd0) &&
                        (bit_idx_q == last_idx_q) && (gap_q == 16'd0)) ||
                       ((state_q == S_GAP) && (gap_cnt_q == 16'd0));

    // A fall that lands on the pulse-end edge itself still stops the burst.
    assign stop_now   = stop_req_q | (fall & busy_q);
    assign last_pulse = (pulse_num_q != 8'd0) && (pulse_cnt_d == pulse_num_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pwm_en_dly_q <= 1'b0;
            stop_req_q   <= 1'b0;
            duty_rld_q   <= '0;
            duty_cnt_q   <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            pulse_num_q  <= '0;
            pulse_cnt_q  <= '0;
            pat_q        <= '0;
            sr_q         <= '0;
            last_idx_q   <= '0;
            bit_idx_q    <= '0;
            pwm_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            pwm_en_dly_q <= pwm_en;
            valid_q      <= 1'b0;

            if (fall && busy_q) begin
                stop_req_q <= 1'b1;
            end

            if (pulse_end) begin
                pulse_cnt_q <= pulse_cnt_d;
                if (stop_now || last_pulse) begin
                    state_q   <= S_DONE;
                    pwm_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    valid_q   <= 1'b1;
                end else begin
                    state_q    <= S_PAT;
                    sr_q       <= pat_q;
                    pwm_out_q  <= pat_q[0];
                    bit_idx_q  <= '0;
                    duty_cnt_q <= duty_rld_q;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        stop_req_q <= 1'b0;
                        if (rise) begin
                            state_q     <= S_PAT;
                            duty_rld_q  <= duty_rld_in;
                            duty_cnt_q  <= duty_rld_in;
                            gap_q       <= pulse_dessert;
                            pulse_num_q <= pulse_num;
                            pulse_cnt_q <= '0;
                            pat_q       <= PAT;
                            sr_q        <= PAT;
                            last_idx_q  <= pat_last_idx;
                            bit_idx_q   <= '0;
                            pwm_out_q   <= PAT[0];
                            busy_q      <= 1'b1;
                        end
                    end

                    S_PAT: begin
                        if (duty_cnt_q != 8'd0) begin
                            duty_cnt_q <= duty_cnt_q - 8'd1;
                        end else if (bit_idx_q != last_idx_q) begin
                            bit_idx_q  <= bit_idx_q + 1'b1;
                            sr_q       <= sr_shift;
                            pwm_out_q  <= sr_shift[0];
                            duty_cnt_q <= duty_rld_q;
                        end else begin
                            // The gap is nonzero here; a zero gap is handled
                            // by the pulse_end branch above.
                            state_q   <= S_GAP;
                            gap_cnt_q <= gap_q - 16'd1;
                            pwm_out_q <= 1'b0;
                        end
                    end

                    S_GAP: begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end

                    S_DONE: begin
                        state_q <= S_IDLE;
                    end

                    default: begin
                        state_q   <= S_IDLE;
                        pwm_out_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pwm_out = pwm_out_q;
    assign busy    = busy_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_pattern_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_pattern_pwm_gen
//   Self-checking bench for pattern_pwm_gen. For each burst, the expected
//   per-clock {pwm_out, busy, valid} samples are pushed to a queue when the
//   burst is launched. They are popped and compared on each falling clock edge.
// ---------------------------------------------------------------------------
module tb_pattern_pwm_gen;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_en;
    logic [7:0]    duty_num;
    logic [15:0]   pulse_dessert;
    logic [7:0]    pulse_num;
    logic [W-1:0]  PAT;
    logic          pwm_out;
    logic          busy;
    logic          valid;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [2:0]    exp_q[$];

    pattern_pwm_gen #(._PAT_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .pwm_en        (pwm_en),
        .duty_num      (duty_num),
        .pulse_dessert (pulse_dessert),
        .pulse_num     (pulse_num),
        .PAT           (PAT),
        .pwm_out       (pwm_out),
        .busy          (busy),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    // Expected waveform for one burst.
    // drop_after < 0: the burst runs pulse_num pulses.
    // Otherwise pwm_en falls right after sample drop_after, so the burst ends
    // at the first pulse boundary at or after sample drop_after+1.
    task automatic push_burst(input int duty, input int gap, input int num,
                              input logic [W-1:0] pat, input int drop_after);
        int eff;
        int len;
        int plen;
        int npulse;
        eff = (duty == 0) ? 1 : duty;
        len = 1;
        for (int i = W - 1; i >= 0; i--) begin
            if (pat[i]) begin
                len = i + 1;
                break;
            end
        end
        plen = len * eff + gap;
        if (drop_after < 0) npulse = num;
        else                npulse = (drop_after + 1 + plen - 1) / plen;
        for (int p = 0; p < npulse; p++) begin
            for (int b = 0; b < len; b++) begin
                for (int d = 0; d < eff; d++) exp_q.push_back({pat[b], 2'b10});
            end
            for (int g = 0; g < gap; g++) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b001);
    endtask

    // Call at a falling edge. Launches a burst and checks every queued sample.
    task automatic run_burst(input string name, input int duty, input int gap,
                             input int num, input logic [W-1:0] pat,
                             input int drop_after, input int idle_after);
        int         idx;
        logic [2:0] exp;
        logic [2:0] got;
        push_burst(duty, gap, num, pat, drop_after);
        for (int k = 0; k < idle_after; k++) exp_q.push_back(3'b000);
        duty_num      = 8'(duty);
        pulse_dessert = 16'(gap);
        pulse_num     = 8'(num);
        PAT           = pat;
        pwm_en        = 1'b1;
        idx           = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {pwm_out, busy, valid};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s sample %0d: pwm/busy/valid got %b expected %b",
                         name, idx, got, exp);
            end
            if (idx == 0) begin
                // Inputs changed after launch must not affect the burst.
                duty_num      = 8'($urandom);
                pulse_dessert = 16'($urandom);
                pulse_num     = 8'($urandom);
                PAT           = W'($urandom);
            end
            if (idx == drop_after) pwm_en = 1'b0;
            idx++;
        end
        pwm_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            got = {pwm_out, busy, valid};
            n_checks++;
            if (got !== 3'b000) begin
                n_fail++;
                $display("FAIL %s idle %0d: pwm/busy/valid got %b expected 000",
                         name, k, got);
            end
        end
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst = 1'b1; pwm_en = 1'b0;
        duty_num = '0; pulse_dessert = '0; pulse_num = '0; PAT = '0;
        repeat (2) @(negedge clk);
        got = {pwm_out, busy, valid};
        n_checks++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: pwm/busy/valid got %b expected 000", got);
        end
        rst = 1'b0;
        @(negedge clk);
        got = {pwm_out, busy, valid};
        n_checks++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: pwm/busy/valid got %b expected 000", got);
        end
    endtask

    task automatic test_pattern_aa();
        run_burst("pat_aa", 1, 16, 2, 16'h00AA, -1, 10);
    endtask

    task automatic test_pattern_ff();
        run_burst("pat_ff", 2, 21, 3, 16'h00FF, -1, 4);
    endtask

    task automatic test_infinite_stop();
        run_burst("inf_stop", 1, 5, 0, 16'h001F, 203, 4);
    endtask

    task automatic test_toggle_stop();
        run_burst("toggle_stop", 1, 1, 0, 16'h0001, 15, 4);
    endtask

    task automatic test_zero_params();
        run_burst("zero_params", 0, 0, 1, 16'h0000, -1, 3);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_a", 3, 2, 2, 16'h8005, -1, 0);
        run_burst("b2b_b", 1, 0, 1, 16'h0006, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] exp;
        logic [2:0] got;
        push_burst(2, 21, 3, 16'h00FF, -1);
        duty_num = 8'd2; pulse_dessert = 16'd21; pulse_num = 8'd3; PAT = 16'h00FF;
        pwm_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {pwm_out, busy, valid};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rst_mid pre %0d: pwm/busy/valid got %b expected %b",
                         i, got, exp);
            end
        end
        exp_q.delete();
        rst = 1'b1; pwm_en = 1'b0;
        for (int i = 0; i < 120; i++) exp_q.push_back(3'b000);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            exp = exp_q.pop_front();
            got = {pwm_out, busy, valid};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rst_mid post %0d: pwm/busy/valid got %b expected %b",
                         i, got, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pattern_aa();
        test_pattern_ff();
        test_infinite_stop();
        test_toggle_stop();
        test_reset_mid_burst();
        test_zero_params();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
